smpl_accum_core: RTL and testbench



---
 rtl/smpl_accum_core.sv | 114 +++++++++++
 tb/tb_smpl_accum_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/smpl_accum_core.sv
// smpl_accum_core: 16-bit accumulator core, multicycle FETCH -> EXEC -> (MEM) -> FETCH.
//
// State table
//   state | meaning
//   FETCH | latch instruction from ROM, advance PC
//   EXEC  | decode IR; issue read/write strobe, jump, or halt
//   MEM   | RAM read data valid; fold it into ACC
//   HALT  | stopped; only reset leaves this state
//
// Ports
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   idata  in   instruction word for iaddr (combinational ROM)
//   iaddr  out  instruction address (PC)
//   datai  in   RAM read data, valid the cycle after renbl
//   datao  out  RAM write data (ACC)
//   daddr  out  RAM address (IR operand field)
//   renbl  out  RAM read request
//   wenbl  out  RAM write strobe
module smpl_accum_core (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] idata,
    output logic [12:0] iaddr,
    input  logic [15:0] datai,
    output logic [15:0] datao,
    output logic [12:0] daddr,
    output logic        renbl,
    output logic        wenbl
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t      state;
    logic [12:0] pc;
    logic [15:0] ir;
    logic [15:0] acc;

    logic [2:0]  opcode;
    logic [12:0] oper;
    logic        op_is_read;

    assign opcode     = ir[15:13];
    assign oper       = ir[12:0];
    assign op_is_read = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                        (opcode == OP_SUB) || (opcode == OP_AND);

    assign iaddr = pc;
    assign daddr = oper;
    assign datao = acc;
    // Both strobes depend on EXEC and mutually exclusive opcodes, so they can never overlap.
    assign renbl = (state == EXEC) && op_is_read;
    assign wenbl = (state == EXEC) && (opcode == OP_STA);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= 13'd0;
            ir    <= 16'd0;
            acc   <= 16'd0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= idata;
                    pc    <= pc + 13'd1;
                    state <= EXEC;
                end
                EXEC: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND: state <= MEM;
                        OP_STA: state <= FETCH;
                        OP_JMP: begin
                            pc    <= oper;
                            state <= FETCH;
                        end
                        OP_JZ: begin
                            if (acc == 16'h0000) pc <= oper;
                            state <= FETCH;
                        end
                        OP_HLT: state <= HALT;
                        default: state <= HALT;
                    endcase
                end
                MEM: begin
                    case (opcode)
                        OP_LDA:  acc <= datai;
                        OP_ADD:  acc <= acc + datai;
                        OP_SUB:  acc <= acc - datai;
                        OP_AND:  acc <= acc & datai;
                        default: acc <= acc;
                    endcase
                    state <= FETCH;
                end
                HALT: state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_smpl_accum_core.sv
// Directed bench for smpl_accum_core with a ROM array and a one-cycle-latency RAM model.
module tb_smpl_accum_core;

    logic        clock;
    logic        reset;
    logic [15:0] idata;
    logic [12:0] iaddr;
    logic [15:0] datai;
    logic [15:0] datao;
    logic [12:0] daddr;
    logic        renbl;
    logic        wenbl;

    logic [15:0] rom [0:8191];
    logic [15:0] ram [0:8191];
    logic [15:0] datai_q;
    logic        use_rand;
    logic [15:0] rnd_i;
    logic [15:0] rnd_d;
    logic        ld_en;
    logic [12:0] ld_addr;
    logic [15:0] ld_data;

    int n_tests = 0;
    int n_fail  = 0;

    smpl_accum_core dut (
        .clock (clock),
        .reset (reset),
        .idata (idata),
        .iaddr (iaddr),
        .datai (datai),
        .datao (datao),
        .daddr (daddr),
        .renbl (renbl),
        .wenbl (wenbl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        idata = rom[iaddr];
        datai = datai_q;
        if (use_rand) begin
            idata = rnd_i;
            datai = rnd_d;
        end
    end

    always @(posedge clock) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (wenbl) ram[daddr] <= datao;
        if (renbl) datai_q <= ram[daddr];
    end

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] a);
        return {op, a};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic ram_load(input logic [12:0] a, input logic [15:0] d);
        @(negedge clock);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clock);
        #1 ld_en = 1'b0;
    endtask

    // Hold reset with random inputs for two cycles; caller loads memories meanwhile.
    task automatic hold_reset();
        reset    = 1'b0;
        use_rand = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            rnd_i = 16'($urandom);
            rnd_d = 16'($urandom);
        end
    endtask

    task automatic release_reset();
        @(negedge clock);
        use_rand = 1'b0;
        reset    = 1'b1;
    endtask

    localparam logic [2:0] LDA = 3'b000, STA = 3'b001, ADD = 3'b010, SUB = 3'b011,
                           ANDI = 3'b100, JMP = 3'b101, JZ = 3'b110, HLT = 3'b111;

    initial begin
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        rnd_i = '0; rnd_d = '0;
        use_rand = 1'b1;
        reset = 1'b0;

        // ---------------- program 1: LDA / ADD / STA / HLT ----------------
        rom[0] = ins(LDA, 13'd10);
        rom[1] = ins(ADD, 13'd11);
        rom[2] = ins(STA, 13'd12);
        rom[3] = ins(HLT, 13'd0);
        hold_reset();
        chk("rst_iaddr", {3'b0, iaddr}, 16'h0000);
        chk("rst_daddr", {3'b0, daddr}, 16'h0000);
        chk("rst_datao", datao, 16'h0000);
        chk("rst_renbl", {15'b0, renbl}, 16'h0000);
        chk("rst_wenbl", {15'b0, wenbl}, 16'h0000);
        ram_load(13'd10, 16'h0005);
        ram_load(13'd11, 16'h0007);
        ram_load(13'd12, 16'h0000);
        release_reset();

        chk("p1_fetch0_iaddr", {3'b0, iaddr}, 16'h0000);
        chk("p1_fetch0_renbl", {15'b0, renbl}, 16'h0000);
        tick(1);
        chk("p1_lda_exec_renbl", {15'b0, renbl}, 16'h0001);
        chk("p1_lda_exec_wenbl", {15'b0, wenbl}, 16'h0000);
        chk("p1_lda_exec_daddr", {3'b0, daddr}, 16'd10);
        chk("p1_lda_exec_iaddr", {3'b0, iaddr}, 16'h0001);
        tick(1);
        chk("p1_lda_mem_renbl", {15'b0, renbl}, 16'h0000);
        chk("p1_lda_mem_acc", datao, 16'h0000);
        tick(1);
        chk("p1_lda_acc", datao, 16'h0005);
        chk("p1_fetch1_iaddr", {3'b0, iaddr}, 16'h0001);
        tick(1);
        chk("p1_add_exec_renbl", {15'b0, renbl}, 16'h0001);
        chk("p1_add_exec_daddr", {3'b0, daddr}, 16'd11);
        tick(1);
        chk("p1_add_mem_renbl", {15'b0, renbl}, 16'h0000);
        tick(1);
        chk("p1_add_acc", datao, 16'h000C);
        tick(1);
        chk("p1_sta_wenbl", {15'b0, wenbl}, 16'h0001);
        chk("p1_sta_renbl", {15'b0, renbl}, 16'h0000);
        chk("p1_sta_daddr", {3'b0, daddr}, 16'd12);
        chk("p1_sta_datao", datao, 16'h000C);
        tick(1);
        chk("p1_sta_wenbl_off", {15'b0, wenbl}, 16'h0000);
        chk("p1_ram12", ram[12], 16'h000C);
        chk("p1_fetch3_iaddr", {3'b0, iaddr}, 16'h0003);
        tick(1);
        chk("p1_hlt_exec_iaddr", {3'b0, iaddr}, 16'h0004);
        tick(4);
        chk("p1_halt_iaddr", {3'b0, iaddr}, 16'h0004);
        chk("p1_halt_renbl", {15'b0, renbl}, 16'h0000);
        chk("p1_halt_wenbl", {15'b0, wenbl}, 16'h0000);
        chk("p1_halt_acc", datao, 16'h000C);

        // ---------------- program 2: SUB wrap, AND, JZ, JMP, PC wrap ----------------
        rom[0]    = ins(LDA,  13'd20);
        rom[1]    = ins(SUB,  13'd21);
        rom[2]    = ins(ANDI, 13'd22);
        rom[3]    = ins(JZ,   13'd30);
        rom[4]    = ins(SUB,  13'd22);
        rom[5]    = ins(JZ,   13'd20);
        rom[20]   = ins(LDA,  13'd23);
        rom[21]   = ins(JZ,   13'd40);
        rom[22]   = ins(JMP,  13'd8191);
        rom[8191] = ins(JMP,  13'd0);
        hold_reset();
        ram_load(13'd20, 16'h0003);
        ram_load(13'd21, 16'h0005);
        ram_load(13'd22, 16'h00F0);
        ram_load(13'd23, 16'h0001);
        release_reset();

        tick(3);
        chk("p2_lda_acc", datao, 16'h0003);
        tick(3);
        chk("p2_sub_wrap", datao, 16'hFFFE);
        tick(3);
        chk("p2_and", datao, 16'h00F0);
        tick(2);
        chk("p2_jz_not_taken", {3'b0, iaddr}, 16'd4);
        tick(3);
        chk("p2_sub_zero", datao, 16'h0000);
        tick(2);
        chk("p2_jz_taken", {3'b0, iaddr}, 16'd20);
        tick(3);
        chk("p2_lda_one", datao, 16'h0001);
        tick(2);
        chk("p2_jz_acc1", {3'b0, iaddr}, 16'd22);
        tick(2);
        chk("p2_jmp_top", {3'b0, iaddr}, 16'd8191);
        tick(1);
        chk("p2_pc_wrap", {3'b0, iaddr}, 16'd0);
        tick(1);
        chk("p2_jmp0", {3'b0, iaddr}, 16'd0);
        chk("p2_jmp0_acc", datao, 16'h0001);

        // ---------------- program 3: reset during MEM of ADD ----------------
        rom[0] = ins(LDA, 13'd10);
        rom[1] = ins(ADD, 13'd11);
        rom[2] = ins(HLT, 13'd0);
        hold_reset();
        ram_load(13'd10, 16'h0005);
        ram_load(13'd11, 16'h0007);
        release_reset();

        tick(5);
        chk("p3_mem_renbl", {15'b0, renbl}, 16'h0000);
        chk("p3_mem_acc", datao, 16'h0005);
        chk("p3_mem_iaddr", {3'b0, iaddr}, 16'd2);
        #2 reset = 1'b0;
        #1;
        chk("p3_async_acc", datao, 16'h0000);
        chk("p3_async_iaddr", {3'b0, iaddr}, 16'd0);
        chk("p3_async_daddr", {3'b0, daddr}, 16'd0);
        @(posedge clock);
        #1;
        chk("p3_hold_acc", datao, 16'h0000);
        release_reset();
        chk("p3_restart_iaddr", {3'b0, iaddr}, 16'd0);
        tick(1);
        chk("p3_restart_renbl", {15'b0, renbl}, 16'h0001);
        tick(2);
        chk("p3_restart_acc", datao, 16'h0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
